spi_burst_ram: RTL and testbench

Parametrised SPI-slave memory with burst transfers: decodes a serial header (opcode + start address) and then streams any number of data words into or out of an internal memory, auto-incrementing and wrapping the address. It replaces the single-word, address-then-data slave/RAM pair as the next-generation serial memory endpoint. The SPI bit clock and the system clock are the same net.

---
 rtl/spi_burst_ram.sv | 104 ++++++++++
 tb/tb_spi_burst_ram.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/spi_burst_ram.sv
// spi_burst_ram: SPI-slave memory with opcode/address header and auto-incrementing, wrapping burst read/write.
// The SPI bit clock is clk; MISO and all state are registered on its rising edge.
module spi_burst_ram #(
   parameter int MEM_DEPTH  = 256,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic SS_n,
   input  logic MOSI,
   output logic MISO,
   output logic busy,
   output logic err
);
   localparam int HW = ADDR_WIDTH + 2;
   localparam int SW = (HW > DATA_WIDTH ? HW : DATA_WIDTH) - 1;
   localparam int CW = $clog2(SW + 1) + 1;
   typedef enum logic [2:0] {IDLE, HDR, WDATA, TURN, RDATA, DROP} state_t;
   state_t state_q;
   logic [CW-1:0] cnt_q;
   logic [SW-1:0] sh_q;
   logic [ADDR_WIDTH-1:0] addr_q, wa_q, addr_nxt;
   logic [DATA_WIDTH-1:0] wd_q, rd_q;
   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
   logic [HW-1:0] hdr;
   logic wp_q, miso_q, err_q, hdr_ok, rd_load, word_end;
   always_comb begin
      hdr = {sh_q[HW-2:0], MOSI};
      hdr_ok = !hdr[HW-1] && (32'(hdr[ADDR_WIDTH-1:0]) < MEM_DEPTH);
      addr_nxt = (addr_q == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : addr_q + 1'b1;
      rd_load = (state_q == RDATA) && (cnt_q == '0);
      word_end = cnt_q == CW'(DATA_WIDTH - 1);
   end
   // Pending write commits one edge late, even if SS_n rises then; rst drops it.
   always_ff @(posedge clk) begin
      if (wp_q && !rst) mem[wa_q] <= wd_q;
      if (state_q == TURN || rd_load) rd_q <= mem[addr_q];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         sh_q <= '0;
         addr_q <= '0;
         wa_q <= '0;
         wd_q <= '0;
         wp_q <= 1'b0;
         miso_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         wp_q <= 1'b0;
         miso_q <= 1'b0;
         if (SS_n) state_q <= IDLE;
         else case (state_q)
            IDLE: begin
               state_q <= HDR;
               sh_q <= SW'(MOSI);
               cnt_q <= CW'(1);
            end
            HDR: begin
               sh_q <= {sh_q[SW-2:0], MOSI};
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(HW - 1)) begin
                  cnt_q <= '0;
                  addr_q <= hdr[ADDR_WIDTH-1:0];
                  state_q <= !hdr_ok ? DROP : hdr[HW-2] ? TURN : WDATA;
                  if (!hdr_ok) err_q <= 1'b1;
               end
            end
            WDATA: begin
               sh_q <= {sh_q[SW-2:0], MOSI};
               cnt_q <= word_end ? '0 : cnt_q + 1'b1;
               if (word_end) begin
                  wp_q <= 1'b1;
                  wa_q <= addr_q;
                  wd_q <= {sh_q[DATA_WIDTH-2:0], MOSI};
                  addr_q <= addr_nxt;
               end
            end
            TURN: begin
               state_q <= RDATA;
               addr_q <= addr_nxt;
            end
            RDATA: begin
               cnt_q <= word_end ? '0 : cnt_q + 1'b1;
               // Load the prefetched word while fetching the next one
               if (rd_load) begin
                  sh_q <= SW'(rd_q[DATA_WIDTH-2:0]);
                  miso_q <= rd_q[DATA_WIDTH-1];
                  addr_q <= addr_nxt;
               end else begin
                  sh_q <= sh_q << 1;
                  miso_q <= sh_q[DATA_WIDTH-2];
               end
            end
            default: ;
         endcase
      end
   end
   assign MISO = miso_q;
   assign busy = state_q != IDLE;
   assign err = err_q;
endmodule

// File: tb/tb_spi_burst_ram.sv
// tb_spi_burst_ram: directed vector table plus hand-written burst, abort, error and reset sequences.
module tb_spi_burst_ram;
   typedef logic [3:0][7:0] wa_t;
   typedef struct {logic rd; logic [7:0] addr; logic [7:0] data;} vec_t;
   logic clk = 1'b0, rst, SS_n, MOSI;
   logic miso0, busy0, err0, miso1, busy1, err1;
   int n_run = 0, n_fail = 0;
   always #5 clk = ~clk;
   spi_burst_ram u0 (.clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso0), .busy(busy0), .err(err0));
   spi_burst_ram #(.MEM_DEPTH(200)) u1 (.clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso1), .busy(busy1), .err(err1));
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic hdr(input logic [1:0] op, input logic [7:0] a);
      logic [9:0] h;
      h = {op, a};
      for (int i = 9; i >= 0; i--) begin
         SS_n = 1'b0;
         MOSI = h[i];
         step();
      end
   endtask
   task automatic stop(input string nm);
      SS_n = 1'b1;
      MOSI = 1'b0;
      step();
      chk({nm, "_busy"}, 32'(busy0), 0);
      chk({nm, "_miso"}, 32'(miso0), 0);
   endtask
   task automatic wr(input logic [7:0] a, input wa_t d, input int n, input int part, input string nm);
      hdr(2'b00, a);
      for (int k = 0; k < n; k++)
         for (int i = 7; i >= 0; i--) begin
            MOSI = d[k][i];
            step();
         end
      for (int j = 0; j < part; j++) begin
         MOSI = ~MOSI;
         step();
      end
      stop(nm);
   endtask
   task automatic rd(input logic [7:0] a, input int n, output wa_t q0, output wa_t q1, input string nm);
      q0 = '0;
      q1 = '0;
      hdr(2'b01, a);
      MOSI = 1'b1;
      step();
      for (int k = 0; k < n; k++)
         for (int i = 7; i >= 0; i--) begin
            step();
            q0[k][i] = miso0;
            q1[k][i] = miso1;
         end
      stop(nm);
   endtask
   initial begin
      vec_t tbl[7];
      wa_t q0, q1, w;
      logic bad;
      tbl[0] = '{1'b0, 8'h10, 8'hA5};
      tbl[1] = '{1'b1, 8'h10, 8'hA5};
      tbl[2] = '{1'b0, 8'h21, 8'h99};
      tbl[3] = '{1'b0, 8'h00, 8'h3C};
      tbl[4] = '{1'b1, 8'h00, 8'h3C};
      tbl[5] = '{1'b1, 8'h21, 8'h99};
      tbl[6] = '{1'b0, 8'h0A, 8'h6E};
      rst = 1'b1;
      SS_n = 1'b1;
      MOSI = 1'b0;
      step();
      step();
      chk("rst_miso", 32'(miso0), 0);
      chk("rst_busy", 32'(busy0), 0);
      chk("rst_err", 32'(err0), 0);
      rst = 1'b0;
      for (int i = 0; i < 7; i++) begin
         if (tbl[i].rd) begin
            rd(tbl[i].addr, 1, q0, q1, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_data", i), 32'(q0[0]), 32'(tbl[i].data));
            chk($sformatf("tbl%0d_err", i), 32'(err0), 0);
         end else begin
            w = '0;
            w[0] = tbl[i].data;
            wr(tbl[i].addr, w, 1, 0, $sformatf("tbl%0d", i));
         end
      end
      // burst across the top of memory
      wr(8'hFE, {8'h44, 8'h33, 8'h22, 8'h11}, 4, 0, "wrap_wr");
      rd(8'hFE, 4, q0, q1, "wrap_rd");
      chk("wrap_rd", 32'(q0), 32'h44332211);
      rd(8'h00, 1, q0, q1, "wrap_m0");
      chk("wrap_m0", 32'(q0[0]), 32'h33);
      // partial trailing word must not be written
      w = '0;
      w[0] = 8'h5C;
      wr(8'h20, w, 1, 5, "part");
      rd(8'h20, 2, q0, q1, "part_rd");
      chk("part_rd", 32'(q0[1:0]), 32'h995C);
      // out-of-range start address on the 200-word instance
      rst = 1'b1;
      step();
      rst = 1'b0;
      hdr(2'b00, 8'd210);
      chk("oor_err1", 32'(err1), 1);
      chk("oor_err0", 32'(err0), 0);
      chk("oor_busy1", 32'(busy1), 1);
      for (int i = 7; i >= 0; i--) begin
         MOSI = i[0];
         step();
      end
      stop("oor");
      rd(8'h0A, 1, q0, q1, "oor_rd");
      chk("oor_mem1", 32'(q1[0]), 32'h6E);
      // reserved opcode goes to DROP and keeps err set
      hdr(2'b11, 8'h10);
      chk("rsv_err", 32'(err0), 1);
      bad = 1'b0;
      for (int i = 0; i < 16; i++) begin
         MOSI = 1'b1;
         step();
         bad |= miso0;
      end
      chk("rsv_miso", 32'(bad), 0);
      chk("rsv_busy", 32'(busy0), 1);
      stop("rsv");
      rd(8'h10, 1, q0, q1, "rsv_rd");
      chk("rsv_mem", 32'(q0[0]), 32'hA5);
      chk("rsv_sticky", 32'(err0), 1);
      // reset during the second word of a read burst
      wr(8'h40, {8'hEF, 8'hBE, 8'hAD, 8'hDE}, 4, 0, "mid_wr");
      hdr(2'b01, 8'h40);
      MOSI = 1'b0;
      step();
      q0 = '0;
      for (int i = 7; i >= 0; i--) begin
         step();
         q0[0][i] = miso0;
      end
      chk("mid_w0", 32'(q0[0]), 32'hDE);
      step();
      step();
      step();
      rst = 1'b1;
      step();
      chk("mid_miso", 32'(miso0), 0);
      chk("mid_busy", 32'(busy0), 0);
      chk("mid_err", 32'(err0), 0);
      rst = 1'b0;
      SS_n = 1'b1;
      step();
      rd(8'h40, 4, q0, q1, "mid_rd");
      chk("mid_rd", 32'(q0), 32'hEFBEADDE);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
